// File: rtl/arm_pipe_pkg.sv
// rtl/arm_pipe_pkg.sv - shared constants and types for the MEM/WB write-port sequencer
package arm_pipe_pkg;

    localparam int WB_EN_BIT    = 3;
    localparam int BASE_UPD_BIT = 2;
    localparam int REG_ADDR_W   = 4;

    typedef enum logic {
        IDLE   = 1'b0,
        SECOND = 1'b1
    } wb_state_t;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clock,
    input  logic             clear,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clock) begin
        if (clear) begin
            count <= '0;
        end else if (inc && (count != {WIDTH{1'b1}})) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/wb_port_sequencer.sv
// rtl/wb_port_sequencer.sv - serialises result and base-register writes onto one register-file port
module wb_port_sequencer
    import arm_pipe_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    input  logic [3:0]            control_wb,
    input  logic [REG_ADDR_W-1:0] address_wb,
    input  logic [REG_ADDR_W-1:0] address_reg_update,
    input  logic [DATA_W-1:0]     data1,
    input  logic [DATA_W-1:0]     data2,
    output logic                  stall,
    output logic                  rf_we,
    output logic [REG_ADDR_W-1:0] rf_waddr,
    output logic [DATA_W-1:0]     rf_wdata,
    output logic [CNT_W-1:0]      dual_count
);

    wb_state_t             state;
    logic [REG_ADDR_W-1:0] hold_addr;
    logic [DATA_W-1:0]     hold_data;

    logic res;
    logic base;
    logic dual;
    logic dual_go;
    logic unused_ctrl;

    assign unused_ctrl = ^control_wb[1:0];

    assign res     = in_valid & control_wb[WB_EN_BIT];
    assign base    = in_valid & control_wb[BASE_UPD_BIT];
    assign dual    = res & base & (address_wb != address_reg_update);
    assign dual_go = dual & (state == IDLE) & ~reset;

    // In IDLE the port follows the inputs directly; SECOND replays the held base write.
    always_comb begin
        stall    = 1'b0;
        rf_we    = 1'b0;
        rf_waddr = '0;
        rf_wdata = '0;
        if (!reset) begin
            case (state)
                IDLE: begin
                    stall = dual;
                    if (res) begin
                        rf_we    = 1'b1;
                        rf_waddr = address_wb;
                        rf_wdata = data2;
                    end else if (base) begin
                        rf_we    = 1'b1;
                        rf_waddr = address_reg_update;
                        rf_wdata = data1;
                    end
                end
                SECOND: begin
                    rf_we    = 1'b1;
                    rf_waddr = hold_addr;
                    rf_wdata = hold_data;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state     <= IDLE;
            hold_addr <= '0;
            hold_data <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (dual) begin
                        state     <= SECOND;
                        hold_addr <= address_reg_update;
                        hold_data <= data1;
                    end
                end
                SECOND:  state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_dual_cnt (
        .clock (clock),
        .clear (reset),
        .inc   (dual_go),
        .count (dual_count)
    );

endmodule

// File: tb/tb_wb_port_sequencer.sv
// tb/tb_wb_port_sequencer.sv - self-checking bench for wb_port_sequencer
module tb_wb_port_sequencer;

    localparam int DATA_W = 32;
    localparam int CNT_W  = 4;
    localparam int CNT_MAX = (1 << CNT_W) - 1;

    logic              clock = 1'b0;
    logic              reset;
    logic              in_valid;
    logic [3:0]        control_wb;
    logic [3:0]        address_wb;
    logic [3:0]        address_reg_update;
    logic [DATA_W-1:0] data1;
    logic [DATA_W-1:0] data2;
    logic              stall;
    logic              rf_we;
    logic [3:0]        rf_waddr;
    logic [DATA_W-1:0] rf_wdata;
    logic [CNT_W-1:0]  dual_count;

    int errors = 0;
    int checks = 0;

    // Reference model: a one-deep queue of deferred base writes plus an event tally.
    bit                m_pend = 0;
    logic [3:0]        m_paddr = '0;
    logic [DATA_W-1:0] m_pdata = '0;
    int                m_cnt = 0;
    bit                prev_stall = 0;

    wb_port_sequencer #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .in_valid           (in_valid),
        .control_wb         (control_wb),
        .address_wb         (address_wb),
        .address_reg_update (address_reg_update),
        .data1              (data1),
        .data2              (data2),
        .stall              (stall),
        .rf_we              (rf_we),
        .rf_waddr           (rf_waddr),
        .rf_wdata           (rf_wdata),
        .dual_count         (dual_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input bit rst, input bit v, input logic [3:0] ctl,
                        input logic [3:0] aw, input logic [3:0] ar,
                        input logic [DATA_W-1:0] d1, input logic [DATA_W-1:0] d2);
        bit                e_we, e_stall, res, base;
        logic [3:0]        e_addr;
        logic [DATA_W-1:0] e_data;
        reset = rst; in_valid = v; control_wb = ctl;
        address_wb = aw; address_reg_update = ar; data1 = d1; data2 = d2;
        @(negedge clock);
        e_we = 0; e_stall = 0; e_addr = '0; e_data = '0;
        res  = v & ctl[3];
        base = v & ctl[2];
        if (rst) begin
            // everything reads as zero
        end else if (m_pend) begin
            e_we = 1; e_addr = m_paddr; e_data = m_pdata;
        end else begin
            if (res) begin
                e_we = 1; e_addr = aw; e_data = d2;
            end else if (base) begin
                e_we = 1; e_addr = ar; e_data = d1;
            end
            e_stall = res && base && (aw != ar);
        end
        check("rf_we", 32'(rf_we), 32'(e_we));
        check("rf_waddr", 32'(rf_waddr), 32'(e_addr));
        check("rf_wdata", rf_wdata, e_data);
        check("stall", 32'(stall), 32'(e_stall));
        check("dual_count", 32'(dual_count), 32'(m_cnt));
        if (prev_stall) check("stall_twice", 32'(stall), 32'd0);
        prev_stall = stall;
        if (rst) begin
            m_pend = 0; m_cnt = 0;
        end else if (m_pend) begin
            m_pend = 0;
        end else if (e_stall) begin
            m_pend = 1; m_paddr = ar; m_pdata = d1;
            if (m_cnt < CNT_MAX) m_cnt++;
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        step(1, 1, 4'b1100, 4, 9, 32'hAAAA_AAAA, 32'h5555_5555);
        step(1, 0, 4'b0000, 0, 0, 0, 0);
        step(0, 0, 4'b0000, 0, 0, 0, 0);

        // result only
        step(0, 1, 4'b1000, 4, 0, 32'h0, 32'h0000_1111);
        // dual write, inputs held across both cycles
        step(0, 1, 4'b1100, 4, 9, 32'h1029_3847, 32'h0000_1111);
        step(0, 1, 4'b1100, 4, 9, 32'h1029_3847, 32'h0000_1111);
        step(0, 0, 4'b0000, 0, 0, 0, 0);
        // equal addresses: base write dropped
        step(0, 1, 4'b1100, 7, 7, 32'hDEAD_BEEF, 32'h0000_2222);
        step(0, 0, 4'b0000, 0, 0, 0, 0);
        // reset during the second cycle of a dual write
        step(0, 1, 4'b1100, 4, 9, 32'h1029_3847, 32'h0000_1111);
        step(1, 1, 4'b1100, 4, 9, 32'h1029_3847, 32'h0000_1111);
        step(0, 0, 4'b0000, 0, 0, 0, 0);
        // base only, then invalid
        step(0, 1, 4'b0100, 3, 9, 32'h1234_5678, 32'h0);
        step(0, 0, 4'b0100, 3, 9, 32'h1234_5678, 32'h0);
        step(0, 0, 4'b1111, 3, 9, 32'h1234_5678, 32'h0);

        // saturation: 17 back-to-back dual events
        for (int i = 0; i < 17; i++) begin
            step(0, 1, 4'b1101, 4'(i), 4'(i + 1), $urandom, $urandom);
            step(0, 1, 4'b1101, 4'(i), 4'(i + 1), $urandom, $urandom);
        end
        step(0, 0, 4'b0000, 0, 0, 0, 0);
        check("saturated", 32'(dual_count), 32'(CNT_MAX));

        step(1, 0, 4'b0000, 0, 0, 0, 0);
        for (int i = 0; i < 400; i++) begin
            logic [3:0] aw, ar;
            aw = 4'($urandom_range(0, 15));
            ar = ($urandom_range(0, 3) == 0) ? aw : 4'($urandom_range(0, 15));
            step(($urandom_range(0, 39) == 0), 1'($urandom_range(0, 3) != 0),
                 4'($urandom), aw, ar, $urandom, $urandom);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
